// File: rtl/el_scan_driver_if.sv
// Nibble stream between a pixel/pattern generator and the EL scan driver.
// The driver owns pix_ready; the source must answer in the same cycle.
interface el_scan_driver_if;
  logic [3:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/el_scan_driver.sv
// EL panel timing master: divides Vclk into panel slots, scans lines/frames,
// pulls one nibble per active slot and drives registered VCLK/HS/VS/D.
module el_scan_driver #(
  parameter int H_ACTIVE = 80,
  parameter int H_BLANK  = 4,
  parameter int V_ACTIVE = 240,
  parameter int V_BLANK  = 2,
  parameter int CLK_DIV  = 4
) (
  input  logic                 Vclk,
  input  logic                 rst,
  el_scan_driver_if.slave      pix,
  input  logic                 underrun_clr,
  output logic                 frame_start,
  output logic                 line_odd,
  output logic                 underrun,
  output logic                 VCLK,
  output logic                 HS,
  output logic                 VS,
  output logic [3:0]           D
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_HBLANK = 2'd1;
  localparam logic [1:0] ST_VBLANK = 2'd2;

  logic [DW-1:0] div_reg, div_next;
  logic [HW-1:0] hcnt_reg, hcnt_next;
  logic [VW-1:0] vcnt_reg, vcnt_next;
  logic [1:0]    state_reg, state_next;
  logic [3:0]    d_reg, d_next;
  logic          vclk_reg, hs_reg, vs_reg, line_odd_reg, underrun_reg;
  logic          tick, fetch, take, miss;

  assign tick = (div_reg == DIV_LAST);

  // Everything below is evaluated for the slot being entered on this tick.
  always_comb begin
    div_next  = tick ? '0 : div_reg + 1'b1;
    hcnt_next = hcnt_reg;
    vcnt_next = vcnt_reg;
    if (tick) begin
      if (hcnt_reg == H_LAST) begin
        hcnt_next = '0;
        vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
      end else begin
        hcnt_next = hcnt_reg + 1'b1;
      end
    end
    if (vcnt_next >= V_ACT)
      state_next = ST_VBLANK;
    else if (hcnt_next >= H_ACT)
      state_next = ST_HBLANK;
    else
      state_next = ST_ACTIVE;
  end

  assign fetch = tick && (state_next == ST_ACTIVE);
  assign take  = fetch && pix.pix_valid;
  assign miss  = fetch && !pix.pix_valid;

  // A missed fetch blanks the slot rather than stalling the scan.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dbit
      assign d_next[gi] = take & pix.pix_data[gi];
    end
  endgenerate

  always_ff @(posedge Vclk or posedge rst) begin
    if (rst) begin
      div_reg      <= '0;
      hcnt_reg     <= H_LAST;
      vcnt_reg     <= V_LAST;
      state_reg    <= ST_VBLANK;
      d_reg        <= '0;
      vclk_reg     <= 1'b0;
      hs_reg       <= 1'b0;
      vs_reg       <= 1'b0;
      line_odd_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      div_reg   <= div_next;
      hcnt_reg  <= hcnt_next;
      vcnt_reg  <= vcnt_next;
      state_reg <= state_next;
      // VCLK falls at each slot boundary so D is stable around the panel's sampling edge.
      vclk_reg  <= (state_next == ST_ACTIVE) && (div_next >= DIV_HALF);
      if (tick) begin
        d_reg        <= d_next;
        hs_reg       <= (hcnt_next == H_ACT);
        vs_reg       <= (vcnt_next == V_ACT);
        line_odd_reg <= vcnt_next[0];
      end
      if (miss)
        underrun_reg <= 1'b1;
      else if (underrun_clr)
        underrun_reg <= 1'b0;
    end
  end

  assign pix.pix_ready = fetch;
  assign frame_start   = tick && (hcnt_next == '0) && (vcnt_next == '0);
  assign line_odd      = line_odd_reg;
  assign underrun      = underrun_reg;
  assign VCLK          = vclk_reg;
  assign HS            = hs_reg;
  assign VS            = vs_reg;
  assign D             = d_reg;

endmodule

// File: tb/tb_el_scan_driver.sv
// Directed bench for el_scan_driver on a 4x3 panel with CLK_DIV=2
// (12-cycle lines, 48-cycle frames); "cycle n" is sampled before edge n.
module tb_el_scan_driver;
  localparam int HA = 4, HB = 2, VA = 3, VB = 1, CD = 2;

  logic       Vclk = 1'b0;
  logic       rst = 1'b1;
  logic       underrun_clr = 1'b0;
  logic       frame_start, line_odd, underrun, VCLK, HS, VS;
  logic [3:0] D;

  el_scan_driver_if pix();

  el_scan_driver #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CLK_DIV(CD)
  ) dut (
    .Vclk(Vclk), .rst(rst), .pix(pix), .underrun_clr(underrun_clr),
    .frame_start(frame_start), .line_odd(line_odd), .underrun(underrun),
    .VCLK(VCLK), .HS(HS), .VS(VS), .D(D)
  );

  always #5 Vclk = ~Vclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {pix.pix_ready, frame_start, line_odd, underrun, VCLK, HS, VS, D};
  endfunction

  task automatic step();
    @(posedge Vclk);
    @(negedge Vclk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    underrun_clr = 1'b0;
    @(negedge Vclk);
    check_val("rst_outs", 32'(outs()), 32'd0);
    @(negedge Vclk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nib, pr_cnt, v, o, m, last_hs, last_vs, last_fs;
    logic exp_ur, exp_fetch, prev_hs, prev_vs;
    bit miss_frame;
    pix.pix_data  = 4'h0;
    pix.pix_valid = 1'b0;

    // Reset release with a constant source
    pix.pix_valid = 1'b1;
    pix.pix_data  = 4'hA;
    do_reset();
    for (int n = 1; n <= 12; n++) begin
      step();
      check_val("s1_ready",  pix.pix_ready, (n == 1 || n == 3 || n == 5 || n == 7));
      check_val("s1_fstart", frame_start, (n == 1));
      check_val("s1_d",      D, (n >= 2 && n <= 9) ? 4'hA : 4'h0);
      check_val("s1_vclk",   VCLK, (n == 3 || n == 5 || n == 7 || n == 9));
      check_val("s1_hs",     HS, (n == 10 || n == 11));
    end
    $display("[tb] reset release: cycles 1..12 checked");

    // Full frame, incrementing nibble source
    do_reset();
    nib = 0;
    pr_cnt = 0;
    for (int n = 1; n <= 49; n++) begin
      step();
      pix.pix_data = 4'(nib);
      v = (n >= 2) ? (n - 2) / 12 : 0;
      o = (n >= 2) ? (n - 2) % 12 : 11;
      check_val("s2_d",    D, (n >= 2 && v < 3 && o < 8) ? 32'(v * 4 + o / 2) : 32'd0);
      check_val("s2_vclk", VCLK, (n >= 2 && v < 3 && o < 8 && (o % 2) == 1));
      check_val("s2_hs",   HS, (n >= 2 && (o == 8 || o == 9)));
      check_val("s2_vs",   VS, (n >= 38));
      check_val("s2_fstart", frame_start, (n == 1 || n == 49));
      if (n < 38)
        check_val("s2_line_odd", line_odd, (n >= 2 && v == 1));
      if (n <= 48 && pix.pix_ready)
        pr_cnt++;
      if (pix.pix_ready)
        nib++;
    end
    check_val("s2_ready_count", pr_cnt, 12);
    $display("[tb] full frame: %0d fetches", pr_cnt);

    // Underrun set, clear, and set-wins-over-clear
    pix.pix_data = 4'h5;
    pix.pix_valid = 1'b1;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      step();
      pix.pix_valid = !(n == 5 || n == 19);
      underrun_clr  = (n == 16 || n == 19);
      if (n >= 4 && n <= 8)
        check_val("s3_d", D, (n == 6 || n == 7) ? 4'h0 : 4'h5);
      if (n == 5)  check_val("s3_ur_before", underrun, 1'b0);
      if (n == 6)  check_val("s3_ur_set", underrun, 1'b1);
      if (n == 15) check_val("s3_ur_sticky", underrun, 1'b1);
      if (n == 17) check_val("s3_ur_clr", underrun, 1'b0);
      if (n == 19) check_val("s3_ready_19", pix.pix_ready, 1'b1);
      if (n == 20) check_val("s3_ur_setwins", underrun, 1'b1);
    end
    underrun_clr = 1'b0;
    pix.pix_valid = 1'b1;
    $display("[tb] underrun: set/clear sequence done");

    // Asynchronous reset mid-frame
    pix.pix_data = 4'hC;
    do_reset();
    for (int n = 1; n <= 19; n++)
      step();
    check_val("s4_d_pre", D, 4'hC);
    check_val("s4_odd_pre", line_odd, 1'b1);
    step();
    rst = 1'b1;
    #1;
    check_val("s4_async", 32'(outs()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge Vclk);
      @(negedge Vclk);
      check_val("s4_held", 32'(outs()), 32'd0);
    end
    rst = 1'b0;
    cyc = 0;
    step();
    check_val("s4_ready", pix.pix_ready, 1'b1);
    check_val("s4_fstart", frame_start, 1'b1);
    step();
    check_val("s4_d", D, 4'hC);
    $display("[tb] mid-frame reset: restart checked");

    // 100 frames with random pix_valid
    do_reset();
    exp_ur = 1'b0;
    pr_cnt = 0;
    last_hs = -1; last_vs = -1; last_fs = -1;
    prev_hs = 1'b0; prev_vs = 1'b0;
    miss_frame = 1'b0;
    for (int n = 1; n <= 100 * 48 + 1; n++) begin
      step();
      m = (n - 1) % 48;
      if (m == 0)
        miss_frame = bit'($urandom_range(0, 1));
      pix.pix_valid = miss_frame ? ($urandom_range(0, 7) != 0) : 1'b1;
      pix.pix_data  = 4'($urandom_range(0, 15));
      underrun_clr  = (m == 1);
      exp_fetch = ((m % 12) % 2 == 0) && ((m % 12) < 8) && (m / 12 < 3);
      if (m == 0) begin
        check_val("s5_underrun", underrun, exp_ur);
        if (n > 1)
          check_val("s5_ready_per_frame", pr_cnt, 12);
        pr_cnt = 0;
      end
      if (m == 2)
        check_val("s5_underrun_clr", underrun, exp_ur);
      if (pix.pix_ready)
        pr_cnt++;
      if (HS && !prev_hs) begin
        if (last_hs > 0) check_val("s5_hs_period", n - last_hs, 12);
        last_hs = n;
      end
      if (VS && !prev_vs) begin
        if (last_vs > 0) check_val("s5_vs_period", n - last_vs, 48);
        last_vs = n;
      end
      if (frame_start) begin
        if (last_fs > 0) check_val("s5_fs_period", n - last_fs, 48);
        last_fs = n;
      end
      prev_hs = HS;
      prev_vs = VS;
      if (exp_fetch && !pix.pix_valid)
        exp_ur = 1'b1;
      else if (underrun_clr)
        exp_ur = 1'b0;
    end
    underrun_clr = 1'b0;
    check_val("s5_fs_seen", (last_fs > 0), 1'b1);
    $display("[tb] long run: 100 frames done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
